axis_ctr_rx: RTL and testbench

Sink-side checker for the AXI-Stream incrementing counter source. Accepts beats on a slave AXI-Stream port, verifies each accepted `tdata` is the previous value plus one (modulo 2^(8·byte_width)), and reports lock state, mismatches, beat and error counts, and upstream handshake violations. Sits directly downstream of the counter transmitter as the terminating stage in stream bring-up and regression benches.

---
 rtl/axis_ctr_rx.sv | 187 ++++++++++++++++++
 tb/tb_axis_ctr_rx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ctr_rx.sv
// ---------------------------------------------------------------------------
// axis_ctr_rx
//
// Terminating sink for the AXI-Stream incrementing counter source. Every
// accepted beat is checked against the previous beat plus one (modulo
// 2^(8*byte_width)). The block reports whether it is locked to the sequence,
// pulses on each out-of-sequence beat, counts beats and errors, and flags
// upstream handshake rule violations.
//
// Configuration macro:
//   AXIS_CTR_RX_STALL_EN - when defined, a 16-bit Fibonacci LFSR
//                          (taps 16,14,13,11) seeded with LFSR_SEED drops
//                          tready whenever lfsr[1:0]==2'b00 (~25% stall).
//                          When undefined, tready stays high once enabled.
//
// Parameters:
//   byte_width - tdata width in bytes (data path is 8*byte_width bits)
//   ERR_CNT_W  - width of the saturating error counter
//   LFSR_SEED  - non-zero LFSR reset value (stall build only)
//
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   clear      in   synchronous clear of counters, proto_err and the checker
//   tvalid     in   upstream beat valid
//   tready     out  this block ready
//   tdata      in   upstream beat data
//   locked     out  checker is locked to the sequence
//   mismatch   out  one-cycle pulse per accepted out-of-sequence beat
//   beat_count out  accepted beats since reset/clear (wraps)
//   err_count  out  mismatches since reset/clear (saturates)
//   proto_err  out  sticky upstream handshake violation flag
// ---------------------------------------------------------------------------
module axis_ctr_rx #(
    parameter int          byte_width = 4,
    parameter int          ERR_CNT_W  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    tvalid,
    output logic                    tready,
    input  logic [8*byte_width-1:0] tdata,
    output logic                    locked,
    output logic                    mismatch,
    output logic [31:0]             beat_count,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    proto_err
);

    localparam int DATA_W = 8 * byte_width;

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_RESYNC  = 2'd2;

    // Saturating increment: test for all-ones first so the counter never wraps.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + ERR_CNT_W'(1);
    endfunction

    logic                     rdy_en;
    logic                     stall;
    logic                     xfer;
    logic [1:0]               state;
    logic [DATA_W-1:0]        expected;
    logic [1:0]               good_run;
    logic                     arm_p1;
    logic [DATA_W-1:0]        tdata_p1;

    // Enable flop: set on the first edge after reset release, so tready is
    // registered and never a combinational function of resetn or tvalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

`ifdef AXIS_CTR_RX_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // LFSR only starts stepping once tready is enabled, so the stall pattern
    // is a fixed function of the seed relative to reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else if (rdy_en) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign tready = rdy_en && !stall;
    assign xfer   = tvalid && tready;
    assign locked = (state == ST_LOCKED);

    // ---- Stage p0 -> p1: sequence checker and counters ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_ACQUIRE;
            expected   <= '0;
            good_run   <= 2'd0;
            mismatch   <= 1'b0;
            beat_count <= 32'd0;
            err_count  <= '0;
        end else begin
            mismatch <= 1'b0;
            if (clear) begin
                // A beat transferred alongside clear is consumed but ignored.
                state      <= ST_ACQUIRE;
                good_run   <= 2'd0;
                beat_count <= 32'd0;
                err_count  <= '0;
            end else if (xfer) begin
                beat_count <= beat_count + 32'd1;
                case (state)
                    ST_ACQUIRE: begin
                        expected <= tdata + DATA_W'(1);
                        state    <= ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        if (tdata == expected) begin
                            expected <= expected + DATA_W'(1);
                        end else begin
                            mismatch  <= 1'b1;
                            err_count <= sat_inc(err_count);
                            expected  <= tdata + DATA_W'(1);
                            good_run  <= 2'd0;
                            state     <= ST_RESYNC;
                        end
                    end
                    ST_RESYNC: begin
                        if (tdata == expected) begin
                            expected <= expected + DATA_W'(1);
                            good_run <= good_run + 2'd1;
                            // Second consecutive good beat re-establishes lock.
                            if (good_run == 2'd1) begin
                                state <= ST_LOCKED;
                            end
                        end else begin
                            mismatch  <= 1'b1;
                            err_count <= sat_inc(err_count);
                            expected  <= tdata + DATA_W'(1);
                            good_run  <= 2'd0;
                        end
                    end
                    default: begin
                        state <= ST_ACQUIRE;
                    end
                endcase
            end
        end
    end

    // ---- Stage p0 -> p1: upstream handshake monitor ----
    // A beat offered while stalled must stay valid with identical data on
    // the following cycle; arm_p1 remembers that a stall was observed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arm_p1    <= 1'b0;
            tdata_p1  <= '0;
            proto_err <= 1'b0;
        end else begin
            arm_p1   <= tvalid && !tready;
            tdata_p1 <= tdata;
            if (clear) begin
                proto_err <= 1'b0;
            end else if (arm_p1 && (!tvalid || (tdata != tdata_p1))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_ctr_rx.sv
// ---------------------------------------------------------------------------
// tb_axis_ctr_rx
//
// Scoreboard bench for axis_ctr_rx with an 8-bit data path and a 4-bit error
// counter. The driver pushes the expected post-beat outputs into a queue at
// each accepted beat; a monitor pops and compares on the cycle after each
// handshake. A separate process compares tready against the expected enable
// and stall pattern.
// ---------------------------------------------------------------------------
module tb_axis_ctr_rx;

    localparam int          BW   = 1;
    localparam int          EW   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          ACQ  = 0;
    localparam int          LCK  = 1;
    localparam int          RSY  = 2;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        clear  = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  tdata  = 8'd0;
    logic        locked;
    logic        mismatch;
    logic [31:0] beat_count;
    logic [3:0]  err_count;
    logic        proto_err;

    always #5 clk = ~clk;

    axis_ctr_rx #(
        .byte_width (BW),
        .ERR_CNT_W  (EW),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .tvalid     (tvalid),
        .tready     (tready),
        .tdata      (tdata),
        .locked     (locked),
        .mismatch   (mismatch),
        .beat_count (beat_count),
        .err_count  (err_count),
        .proto_err  (proto_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        mm;
        logic        lk;
        logic [31:0] bc;
        logic [3:0]  ec;
    } exp_t;

    exp_t       sb[$];
    int         m_mode  = ACQ;
    logic [7:0] m_next  = 8'd0;
    int         m_run   = 0;
    int         m_beats = 0;
    int         m_errs  = 0;

    task automatic model_reset();
        m_mode  = ACQ;
        m_run   = 0;
        m_beats = 0;
        m_errs  = 0;
    endtask

    // Next value wanted is always last accepted value + 1 mod 256.
    task automatic model_beat(input logic [7:0] d, input bit clr);
        exp_t e;
        bit   bad;
        if (clr) begin
            model_reset();
            e = '0;
            sb.push_back(e);
            return;
        end
        bad = (m_mode != ACQ) && (d != m_next);
        if (m_mode == ACQ) begin
            m_mode = LCK;
        end else if (bad) begin
            m_mode = RSY;
            m_run  = 0;
            if (m_errs < 15) m_errs++;
        end else if (m_mode == RSY) begin
            m_run++;
            if (m_run == 2) m_mode = LCK;
        end
        m_next = d + 8'd1;
        m_beats++;
        e.mm = bad;
        e.lk = (m_mode == LCK);
        e.bc = 32'(m_beats);
        e.ec = 4'(m_errs);
        sb.push_back(e);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: handshake seen, 0 expectations queued, needed 1");
                end else begin
                    e = sb.pop_front();
                    check("mismatch",   mismatch,   e.mm);
                    check("locked",     locked,     e.lk);
                    check("beat_count", beat_count, e.bc);
                    check("err_count",  err_count,  e.ec);
                end
            end else if (resetn) begin
                check("mismatch_idle", mismatch, 1'b0);
            end
            pend = resetn && tvalid && tready;
        end
    end

    // ---------------- tready reference ----------------
    initial begin
        int          n;
        logic [15:0] lf;
        logic        want;
        n  = 0;
        lf = SEED;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                n  = 0;
                lf = SEED;
            end else begin
`ifdef AXIS_CTR_RX_STALL_EN
                want = (n == 0) ? 1'b0 : (lf[1:0] != 2'b00);
`else
                want = (n == 0) ? 1'b0 : 1'b1;
`endif
                check("tready", tready, want);
                if (n >= 1) lf = lfsr_next(lf);
                n++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] d, input bit clr);
        int waited;
        waited = 0;
        tdata  = d;
        tvalid = 1'b1;
        clear  = clr;
        forever begin
            @(negedge clk);
            if (tready) break;
            waited++;
            if (waited > 100) begin
                n_total++;
                $display("FAIL drive_timeout: tready 0 for 100 cycles, needed 1");
                tvalid = 1'b0;
                clear  = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        model_beat(d, clr);
        #1;
        clear = 1'b0;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic do_clear();
        tvalid = 1'b0;
        clear  = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_beat_count", beat_count, 32'd0);
        check("clr_err_count",  err_count,  4'd0);
        check("clr_locked",     locked,     1'b0);
        check("clr_proto_err",  proto_err,  1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"},     tready,     1'b0);
        check({tag, "_locked"},     locked,     1'b0);
        check({tag, "_mismatch"},   mismatch,   1'b0);
        check({tag, "_beat_count"}, beat_count, 32'd0);
        check({tag, "_err_count"},  err_count,  4'd0);
        check({tag, "_proto_err"},  proto_err,  1'b0);
    endtask

    logic [7:0] seq1 [6];
    logic [7:0] seq2 [4];

    initial begin
        logic [7:0] v;
        seq1 = '{8'd5, 8'd6, 8'd9, 8'd10, 8'd11, 8'd12};
        seq2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset and release with a continuous source.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) drive(8'(i), 1'b0);
        idle();
        check("run_beat_count", beat_count, 32'd100);
        check("run_err_count",  err_count,  4'd0);
        check("run_locked",     locked,     1'b1);
        check("run_proto_err",  proto_err,  1'b0);

        // Single glitch then resync.
        do_clear();
        for (int i = 0; i < 6; i++) drive(seq1[i], 1'b0);
        idle();
        check("glitch_err_count",  err_count,  4'd1);
        check("glitch_locked",     locked,     1'b1);
        check("glitch_beat_count", beat_count, 32'd6);

        // Modular wrap.
        do_clear();
        for (int i = 0; i < 4; i++) drive(seq2[i], 1'b0);
        idle();
        check("wrap_err_count", err_count, 4'd0);
        check("wrap_locked",    locked,    1'b1);

        // Error counter saturation.
        do_clear();
        v = 8'($urandom);
        drive(v, 1'b0);
        for (int i = 0; i < 20; i++) begin
            v = v + 8'd1 + 8'($urandom_range(1, 254));
            drive(v, 1'b0);
        end
        idle();
        check("sat_err_count", err_count, 4'd15);

        // Clear coincident with a transfer.
        drive(8'd7, 1'b1);
        drive(8'd20, 1'b0);
        drive(8'd21, 1'b0);
        idle();
        check("clrx_beat_count", beat_count, 32'd2);
        check("clrx_err_count",  err_count,  4'd0);
        check("clrx_locked",     locked,     1'b1);

        // Randomised stream with gaps and occasional clears.
        v = 8'($urandom);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) v = v + 8'd1;
            else v = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 59) == 0) do_clear();
            drive(v, 1'b0);
        end
        idle();

        // Asynchronous reset mid-stream, then an upstream violation on release.
        for (int i = 0; i < 4; i++) drive(8'(8'd40 + 8'(i)), 1'b0);
        idle();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async");
        check("sb_empty_at_reset", sb.size(), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tvalid = 1'b1;
        tdata  = 8'h33;
        @(posedge clk);
        #1;
        drive(8'h44, 1'b0);
        drive(8'h45, 1'b0);
        idle();
        check("proto_set", proto_err, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("proto_sticky", proto_err, 1'b1);
        do_clear();

`ifdef AXIS_CTR_RX_STALL_EN
        // Drop tvalid after a stalled offer.
        begin
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (tready && guard < 200);
            #1;
            tvalid = 1'b1;
            tdata  = 8'h55;
            @(posedge clk);
            #1;
            tvalid = 1'b0;
            @(posedge clk);
            #1;
            check("stall_proto_set", proto_err, 1'b1);
            do_clear();
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
